// File: rtl/vec_pkg.sv
// Shared types, widths and per-opcode decode helpers for the vector execute stage.
package vec_pkg;

    localparam int LANES  = 3;
    localparam int LANE_W = 18;
    localparam int REG_AW = 4;
    localparam int FRAC   = 8;

    typedef logic [LANE_W-1:0]  lane_t;
    typedef lane_t [LANES-1:0]  vec_t;
    typedef logic [REG_AW-1:0]  reg_idx_t;

    localparam lane_t LANE_MAX = '1;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_MUL    = 3'd2,
        OP_MAC    = 3'd3,
        OP_ACCRD  = 3'd4,
        OP_ACCCLR = 3'd5,
        OP_MAX    = 3'd6,
        OP_RSVD   = 3'd7
    } vec_op_e;

    // Accumulator-only ops and the reserved code never look at the register file.
    function automatic logic reads_src1(vec_op_e op);
        return !(op inside {OP_ACCRD, OP_ACCCLR, OP_RSVD});
    endfunction

    function automatic logic reads_src2(vec_op_e op);
        return !(op inside {OP_ACCRD, OP_ACCCLR, OP_RSVD});
    endfunction

    function automatic logic writes_dst(vec_op_e op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_ACCRD, OP_MAX};
    endfunction

    // True when an incoming op would read the register a pending stage is about to write.
    function automatic logic src_conflict(reg_idx_t pend_dst, vec_op_e op,
                                          reg_idx_t s1_idx, reg_idx_t s2_idx);
        return (reads_src1(op) && (pend_dst == s1_idx)) ||
               (reads_src2(op) && (pend_dst == s2_idx));
    endfunction

endpackage

// File: rtl/vec_exec_unit_if.sv
// Issue port and register-file write port of the vector execute stage.
interface vec_exec_unit_if;
    import vec_pkg::*;

    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    reg_idx_t   src1_idx;
    reg_idx_t   src2_idx;
    reg_idx_t   dst_idx;
    vec_t       src_a;
    vec_t       src_b;
    logic       we3;
    reg_idx_t   ra3;
    vec_t       wd3;
    logic       busy;

    modport master (
        output in_valid, op, src1_idx, src2_idx, dst_idx, src_a, src_b,
        input  in_ready, we3, ra3, wd3, busy
    );

    modport slave (
        input  in_valid, op, src1_idx, src2_idx, dst_idx, src_a, src_b,
        output in_ready, we3, ra3, wd3, busy
    );
endinterface

// File: rtl/vec_lane_alu.sv
// One lane of saturating arithmetic plus that lane's accumulator.
module vec_lane_alu
    import vec_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  vec_op_e op,
    input  lane_t   a,
    input  lane_t   b,
    output lane_t   result
);
    // Width of a full product after the fixed-point shift.
    localparam int SW = 2*LANE_W - FRAC;

    lane_t                acc_reg;
    lane_t                acc_next;
    logic [LANE_W:0]      sum;
    logic [2*LANE_W-1:0]  prod;
    logic [SW-1:0]        scaled;
    lane_t                scaled_sat;
    logic [SW:0]          acc_sum;

    // Lane result and next accumulator value from the S1 operands.
    always_comb begin
        sum        = {1'b0, a} + {1'b0, b};
        prod       = (2*LANE_W)'(a) * (2*LANE_W)'(b);
        scaled     = SW'(prod >> FRAC);
        scaled_sat = (|scaled[SW-1:LANE_W]) ? LANE_MAX : scaled[LANE_W-1:0];
        acc_sum    = {{(SW+1-LANE_W){1'b0}}, acc_reg} + {1'b0, scaled};

        result = '0;
        case (op)
            OP_ADD:   result = sum[LANE_W] ? LANE_MAX : sum[LANE_W-1:0];
            OP_SUB:   result = (a < b) ? '0 : (a - b);
            OP_MUL:   result = scaled_sat;
            OP_ACCRD: result = acc_reg;
            OP_MAX:   result = (a > b) ? a : b;
            default:  result = '0;
        endcase

        acc_next = acc_reg;
        if (en) begin
            case (op)
                OP_MAC:    acc_next = (|acc_sum[SW:LANE_W]) ? LANE_MAX : acc_sum[LANE_W-1:0];
                OP_ACCRD:  acc_next = '0;
                OP_ACCCLR: acc_next = '0;
                default:   acc_next = acc_reg;
            endcase
        end
    end

    // Accumulator advances as an op leaves S1, so updates follow issue order.
    always_ff @(posedge clk) begin
        if (rst) acc_reg <= '0;
        else     acc_reg <= acc_next;
    end

endmodule

// File: rtl/vec_exec_unit.sv
// Two-stage vector execute unit with a read-after-write scoreboard on issue.
module vec_exec_unit
    import vec_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    vec_exec_unit_if.slave  bus
);
    vec_op_e  in_op;
    logic     hazard;
    logic     accept;

    logic     s1_valid_reg;
    vec_op_e  s1_op_reg;
    reg_idx_t s1_dst_reg;
    vec_t     s1_a_reg;
    vec_t     s1_b_reg;

    logic     s2_valid_reg;
    logic     s2_writes_reg;
    reg_idx_t ra3_reg;
    vec_t     wd3_reg;

    vec_t     alu_result;

    // Stall issue while a pending write targets a register the new op reads.
    // ra3_reg is the S2 destination whenever S2 writes.
    always_comb begin
        in_op  = vec_op_e'(bus.op);
        hazard = 1'b0;
        if (s1_valid_reg && writes_dst(s1_op_reg) &&
            src_conflict(s1_dst_reg, in_op, bus.src1_idx, bus.src2_idx))
            hazard = 1'b1;
        if (s2_valid_reg && s2_writes_reg &&
            src_conflict(ra3_reg, in_op, bus.src1_idx, bus.src2_idx))
            hazard = 1'b1;
        accept = bus.in_valid && !hazard && !rst;
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            vec_lane_alu u_alu (
                .clk    (clk),
                .rst    (rst),
                .en     (s1_valid_reg),
                .op     (s1_op_reg),
                .a      (s1_a_reg[gi]),
                .b      (s1_b_reg[gi]),
                .result (alu_result[gi])
            );
        end
    endgenerate

    // S1 captures the issued op; S2 captures the result, and the write port holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_op_reg     <= OP_ADD;
            s1_dst_reg    <= '0;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s2_valid_reg  <= 1'b0;
            s2_writes_reg <= 1'b0;
            ra3_reg       <= '0;
            wd3_reg       <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_op_reg  <= in_op;
                s1_dst_reg <= bus.dst_idx;
                s1_a_reg   <= bus.src_a;
                s1_b_reg   <= bus.src_b;
            end
            s2_valid_reg  <= s1_valid_reg;
            s2_writes_reg <= s1_valid_reg && writes_dst(s1_op_reg);
            if (s1_valid_reg && writes_dst(s1_op_reg)) begin
                ra3_reg <= s1_dst_reg;
                wd3_reg <= alu_result;
            end
        end
    end

    assign bus.in_ready = !hazard;
    assign bus.we3      = s2_valid_reg && s2_writes_reg;
    assign bus.ra3      = ra3_reg;
    assign bus.wd3      = wd3_reg;
    assign bus.busy     = s1_valid_reg || s2_valid_reg;

endmodule

// File: tb/tb_vec_exec_unit.sv
// Directed, table-driven bench for vec_exec_unit with a behavioural register file.
module tb_vec_exec_unit;
    import vec_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec_exec_unit_if bus ();

    vec_exec_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int we_count = 0;

    logic rf_mode = 1'b0;
    vec_t drv_a   = '0;
    vec_t drv_b   = '0;
    vec_t rf [16] = '{default: '0};

    // Register file: combinational read, write on the clock edge.
    always_comb begin
        bus.src_a = rf_mode ? rf[bus.src1_idx] : drv_a;
        bus.src_b = rf_mode ? rf[bus.src2_idx] : drv_b;
    end

    always @(posedge clk) begin
        if (bus.we3) begin
            rf[bus.ra3] <= bus.wd3;
            we_count    <= we_count + 1;
        end
    end

    typedef struct {
        logic [2:0] op;
        vec_t       a;
        vec_t       b;
        logic [3:0] dst;
        logic       exp_we;
        logic [3:0] exp_ra;
        vec_t       exp_wd;
    } vec_rec_t;

    vec_rec_t tbl [8];

    function automatic vec_t mkv(input int l0, input int l1, input int l2);
        return {lane_t'(l2), lane_t'(l1), lane_t'(l0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [3:0] dst, input vec_t a, input vec_t b);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.src1_idx = s1;
        bus.src2_idx = s2;
        bus.dst_idx  = dst;
        drv_a        = a;
        drv_b        = b;
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.src1_idx = 4'd15;
        bus.src2_idx = 4'd15;
        #1;
    endtask

    int base;

    initial begin
        bus.in_valid = 1'b0;
        bus.op       = 3'd0;
        bus.src1_idx = 4'd15;
        bus.src2_idx = 4'd15;
        bus.dst_idx  = 4'd0;

        tbl[0] = '{OP_ADD, mkv(100, 5, 262143), mkv(200, 9, 1), 4'd1, 1'b1, 4'd1, mkv(300, 14, 262143)};
        tbl[1] = '{OP_SUB, mkv(5, 0, 1000), mkv(9, 0, 1), 4'd2, 1'b1, 4'd2, mkv(0, 0, 999)};
        tbl[2] = '{OP_MUL, mkv(512, 131072, 0), mkv(300, 131072, 7), 4'd4, 1'b1, 4'd4, mkv(600, 262143, 0)};
        tbl[3] = '{OP_MAX, mkv(1, 500, 262143), mkv(2, 499, 0), 4'd5, 1'b1, 4'd5, mkv(2, 500, 262143)};
        tbl[4] = '{OP_RSVD, mkv(7, 7, 7), mkv(7, 7, 7), 4'd6, 1'b0, 4'd5, mkv(2, 500, 262143)};
        tbl[5] = '{OP_ADD, mkv(262143, 262143, 0), mkv(1, 262143, 0), 4'd6, 1'b1, 4'd6, mkv(262143, 262143, 0)};
        tbl[6] = '{OP_MUL, mkv(255, 256, 1), mkv(1, 1, 256), 4'd8, 1'b1, 4'd8, mkv(0, 1, 1)};
        tbl[7] = '{OP_SUB, mkv(7, 7, 7), mkv(7, 7, 7), 4'd9, 1'b1, 4'd9, mkv(0, 0, 0)};

        // Reset and reset values.
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("rst_we3", 64'(bus.we3), 64'd0);
        check("rst_ra3", 64'(bus.ra3), 64'd0);
        check("rst_wd3", 64'(bus.wd3), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ready", 64'(bus.in_ready), 64'd1);
        step();

        // Single-op vectors: write appears two cycles after issue.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].op, 4'd15, 4'd15, tbl[i].dst, tbl[i].a, tbl[i].b);
            check($sformatf("tbl%0d_ready", i), 64'(bus.in_ready), 64'd1);
            step();
            idle();
            check($sformatf("tbl%0d_we_t1", i), 64'(bus.we3), 64'd0);
            step();
            check($sformatf("tbl%0d_we3", i), 64'(bus.we3), 64'(tbl[i].exp_we));
            check($sformatf("tbl%0d_ra3", i), 64'(bus.ra3), 64'(tbl[i].exp_ra));
            check($sformatf("tbl%0d_wd3", i), 64'(bus.wd3), 64'(tbl[i].exp_wd));
            step();
        end

        // MAC x3 then ACCRD immediately after the last MAC.
        base = we_count;
        for (int i = 0; i < 3; i++) begin
            drive(OP_MAC, 4'd15, 4'd15, 4'd0, mkv(256, 256, 256), mkv(10, 20, 30));
            step();
        end
        drive(OP_ACCRD, 4'd15, 4'd15, 4'd7, '0, '0);
        step();
        idle();
        step();
        check("mac_no_writes", 64'(we_count), 64'(base));
        check("accrd_we3", 64'(bus.we3), 64'd1);
        check("accrd_ra3", 64'(bus.ra3), 64'd7);
        check("accrd_wd3", 64'(bus.wd3), 64'(mkv(30, 60, 90)));
        step();
        drive(OP_ACCRD, 4'd15, 4'd15, 4'd8, '0, '0);
        step();
        idle();
        step();
        check("accrd2_ra3", 64'(bus.ra3), 64'd8);
        check("accrd2_wd3", 64'(bus.wd3), 64'd0);
        step();

        // ACCCLR discards earlier MAC contributions.
        drive(OP_MAC, 4'd15, 4'd15, 4'd0, mkv(256, 256, 256), mkv(5, 5, 5));
        step();
        drive(OP_ACCCLR, 4'd15, 4'd15, 4'd0, '0, '0);
        step();
        drive(OP_MAC, 4'd15, 4'd15, 4'd0, mkv(256, 256, 256), mkv(1, 2, 3));
        step();
        drive(OP_ACCRD, 4'd15, 4'd15, 4'd10, '0, '0);
        step();
        idle();
        step();
        check("accclr_ra3", 64'(bus.ra3), 64'd10);
        check("accclr_wd3", 64'(bus.wd3), 64'(mkv(1, 2, 3)));
        step();

        // RAW hazard: producer writes r3, consumer reads r3 from the next cycle.
        rf_mode = 1'b0;
        drive(OP_ADD, 4'd15, 4'd15, 4'd3, mkv(10, 20, 30), mkv(1, 1, 1));
        step();
        rf_mode = 1'b1;
        drive(OP_ADD, 4'd3, 4'd3, 4'd11, '0, '0);
        check("hz_ready_t1", 64'(bus.in_ready), 64'd0);
        step();
        check("hz_ready_t2", 64'(bus.in_ready), 64'd0);
        check("hz_we_t2", 64'(bus.we3), 64'd1);
        step();
        check("hz_ready_t3", 64'(bus.in_ready), 64'd1);
        step();
        idle();
        check("hz_we_t4", 64'(bus.we3), 64'd0);
        step();
        check("hz_we3", 64'(bus.we3), 64'd1);
        check("hz_ra3", 64'(bus.ra3), 64'd11);
        check("hz_wd3", 64'(bus.wd3), 64'(mkv(22, 42, 62)));
        step();

        // Independent op after a write, then ACCRD whose idx fields match a pending dst.
        rf_mode = 1'b0;
        drive(OP_ADD, 4'd15, 4'd15, 4'd3, mkv(1, 1, 1), mkv(1, 1, 1));
        step();
        rf_mode = 1'b1;
        drive(OP_ADD, 4'd4, 4'd5, 4'd13, '0, '0);
        check("ind_ready_t1", 64'(bus.in_ready), 64'd1);
        step();
        drive(OP_ACCRD, 4'd13, 4'd13, 4'd14, '0, '0);
        check("accrd_nosrc_ready", 64'(bus.in_ready), 64'd1);
        step();
        idle();
        check("ind_ra3", 64'(bus.ra3), 64'd13);
        check("ind_wd3", 64'(bus.wd3), 64'(mkv(602, 262143, 262143)));
        step();
        check("nosrc_ra3", 64'(bus.ra3), 64'd14);
        check("nosrc_wd3", 64'(bus.wd3), 64'd0);
        rf_mode = 1'b0;
        step();
        step();

        // Ten back-to-back independent ops.
        for (int c = 0; c < 13; c++) begin
            if (c < 10) drive(OP_ADD, 4'd15, 4'd15, 4'(c), mkv(c, 0, 0), mkv(100, 0, 0));
            else        idle();
            if (c < 10) check($sformatf("b2b%0d_ready", c), 64'(bus.in_ready), 64'd1);
            if (c >= 2 && c < 12) begin
                check($sformatf("b2b%0d_we3", c), 64'(bus.we3), 64'd1);
                check($sformatf("b2b%0d_ra3", c), 64'(bus.ra3), 64'(c - 2));
                check($sformatf("b2b%0d_wd3", c), 64'(bus.wd3), 64'(mkv(c - 2 + 100, 0, 0)));
            end
            if (c == 11) check("b2b_busy_t11", 64'(bus.busy), 64'd1);
            if (c == 12) begin
                check("b2b_busy_t12", 64'(bus.busy), 64'd0);
                check("b2b_we_t12", 64'(bus.we3), 64'd0);
            end
            step();
        end

        // Reset while MAC and ADD are in flight.
        base = we_count;
        drive(OP_MAC, 4'd15, 4'd15, 4'd0, mkv(256, 256, 256), mkv(100, 100, 100));
        step();
        drive(OP_ADD, 4'd15, 4'd15, 4'd4, mkv(1, 1, 1), mkv(1, 1, 1));
        step();
        rst = 1'b1;
        drive(OP_ADD, 4'd15, 4'd15, 4'd9, mkv(2, 2, 2), mkv(2, 2, 2));
        step();
        rst = 1'b0;
        idle();
        check("mid_rst_we3", 64'(bus.we3), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_ra3", 64'(bus.ra3), 64'd0);
        check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
        step();
        step();
        check("mid_rst_no_writes", 64'(we_count), 64'(base));
        drive(OP_ACCRD, 4'd15, 4'd15, 4'd6, '0, '0);
        step();
        idle();
        step();
        check("post_rst_accrd_we3", 64'(bus.we3), 64'd1);
        check("post_rst_accrd_ra3", 64'(bus.ra3), 64'd6);
        check("post_rst_accrd_wd3", 64'(bus.wd3), 64'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vec_exec_unit.md
# vec_exec_unit

Vector execute stage for the filter GPU datapath. It consumes the two 3-lane × 18-bit operands read from the vector register file. It performs lane-wise saturating arithmetic, including a per-lane multiply-accumulate for convolution kernels, and drives the register file write port two cycles after issue. A small scoreboard stalls issue on read-after-write hazards, because the register file reads combinationally and writes on the clock edge.

## Interface
- `LANES`, 3, lanes per vector
- `LANE_W`, 18, bits per lane (unsigned pixel data)
- `FRAC`, 8, fractional bits for MUL/MAC fixed-point scaling
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  issue request
- `in_ready`  out  1  issue accepted when `in_valid & in_ready`
- `op`  in  3  opcode (see Operation)
- `src1_idx`, `src2_idx`  in  4  register indices of the operands, used only by the scoreboard
- `dst_idx`  in  4  destination register
- `src_a`, `src_b`  in  [LANES][LANE_W]  operand vectors (register file `rd1`, `rd2`)
- `we3`  out  1  register file write enable
- `ra3`  out  4  write address
- `wd3`  out  [LANES][LANE_W]  write data
- `busy`  out  1  any pipeline stage valid

## Operation
- Opcodes:
  - ADD=0: a+b, saturate at 2^18−1.
  - SUB=1: a−b, clamp at 0.
  - MUL=2: (a·b)>>FRAC, saturate.
  - MAC=3: acc ← sat(acc + (a·b)>>FRAC), no register write.
  - ACCRD=4: write acc to dst, then clear acc.
  - ACCCLR=5: acc ← 0, no write.
  - MAX=6: lane-wise maximum.
  - 7 is reserved. It is accepted and behaves as a no-op with no write.
- All lane operations are independent. Products are computed at full 36-bit width, then shifted, then saturated to 18 bits.
- `acc` is a per-lane 18-bit saturating accumulator.
- Pipeline:
  - S1 holds the registered op, dst and operands.
  - S2 holds the registered result, the write flag and dst.
  - `we3` = S2.valid & S2.writes.
- Scoreboard rules:
  - `in_ready` = !(hazard).
  - A hazard exists if S1 or S2 is valid, that stage writes, and its dst equals `src1_idx` or `src2_idx` of an op that reads that source.
  - ACCRD, ACCCLR and reserved read no source.
  - `in_ready` is combinational from the idx inputs.
  - Ops without a hazard issue every cycle.
- Accumulator ordering:
  - `acc` updates at the S1→S2 edge, in issue order.
  - An ACCRD issued the cycle after a MAC sees that MAC's contribution.
- Reset:
  - S1/S2 valid ← 0 and acc ← 0.
  - No write occurs from an op in flight.
  - The op presented in the reset cycle is not accepted.

## Timing
- Reset values: `we3`=0, `ra3`=0, `wd3`=0, `busy`=0, `in_ready`=1 once `rst` deasserts.
- Op accepted in cycle T:
  - S1 is valid in T+1.
  - `we3` is high in T+2 with the result.
  - The register file updates at the end of T+2.
- Write latency is 2 cycles. Throughput is 1 op/cycle when there is no hazard.
- A dependent op presented in T+1 sees `in_ready`=0 in T+1 and T+2, and is accepted in T+3.
- `in_valid` may drop during a stall without error.
- There is no requirement to hold inputs stable while stalled, because each issue is re-evaluated every cycle.
- `ra3`/`wd3` hold their last value when `we3`=0.

## Structure
- Package `vec_pkg` holds:
  - `LANES`, `LANE_W`, `REG_AW`=4, `FRAC`;
  - `lane_t`, `vec_t`;
  - the `vec_op_e` enum;
  - the per-op helpers `reads_src1`, `reads_src2`, `writes_dst`.
- Sub-module `vec_lane_alu`:
  - one lane of combinational arithmetic plus its accumulator register;
  - instantiated LANES times.
- Top level holds the S1/S2 registers and the scoreboard.

## Test plan
- Reset, then ADD on lanes (100,5,262143) + (200,9,1) → `we3` at T+2 with `wd3`=(300,14,262143).
- SUB (5,0,1000) − (9,0,1) → (0,0,999). MUL 512·300 with FRAC=8 → 600. MUL 2^17·2^17 → 262143.
- MAC ×3 with a=(256,256,256), b=(10,20,30), then ACCRD to r7 → r7=(30,60,90) with no writes before ACCRD. A second ACCRD → (0,0,0).
- ADD writing r3, then an op reading r3 presented every cycle → `in_ready` low for 2 cycles, accepted at T+3, result uses the updated r3. An independent op instead is accepted at T+1.
- Back-to-back independent ops for 10 cycles → 10 consecutive `we3` pulses with correct `ra3` sequence. `busy` falls 2 cycles after the last issue.
- Assert `rst` while MAC and ADD are in flight → no `we3` pulse, acc=0. A following ACCRD writes (0,0,0).
